wb_spi_flash_rd: RTL
====================

Name: wb_spi_flash_rd

Overview:
Wishbone target that services 32-bit read requests by issuing SPI flash READ (0x03) transactions as the SPI initiator. It drives the same flash_sck/csn/sdo/sdi pins that spi_target_bfm responds to, and forms the flash-read path of clusterv_soc. Writes are refused with an error.

Parameters:
ADDR_WIDTH, 32, Wishbone address width; only adr[23:2] is used.
CLK_DIV, 2, SCK half-period in clock cycles; must be >= 1.
CSN_GAP, 2, minimum clocks csn stays high between transactions; must be >= 1.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
t_adr  input  ADDR_WIDTH  Wishbone byte address.
t_dat_w  input  32  write data (unused).
t_dat_r  output  32  read data.
t_cyc  input  1  bus cycle.
t_stb  input  1  strobe.
t_we  input  1  write enable.
t_sel  input  4  byte selects (ignored; full word always read).
t_ack  output  1  read complete.
t_err  output  1  write rejected.
flash_sck  output  1  SPI clock, mode 0, idles low.
flash_csn  output  1  chip select, active low.
flash_sdo  output  1  initiator-to-flash data.
flash_sdi  input  1  flash-to-initiator data.

Behaviour:
- One clock; reset is synchronous and active-high. On reset: flash_csn=1, flash_sck=0, flash_sdo=0, t_ack=0, t_err=0, t_dat_r=0, state=IDLE, gap counter cleared. Reset mid-transaction aborts immediately with no ack.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE, request seen (cycle 0) with t_cyc&t_stb&t_we: t_err=1 for exactly cycle 1, no pin activity, then IDLE. Master must drop stb after err.
- IDLE, request seen (cycle 0) with t_cyc&t_stb&!t_we: load the 32-bit out-shift register with {8'h03, t_adr[23:2], 2'b00}. Upper address bits are ignored, and adr[1:0] are forced to 0. Go to SHIFT.
- SHIFT, cycle 1: csn=0, sck=0, sdo=MSB. sck toggles every CLK_DIV clocks.
  - Rising edge k (k=0..63) occurs at cycle 1+(2k+1)*CLK_DIV.
  - sdi is sampled into the in-shift register on rising edges k=32..63. Sampling at rising edges k=0..31 is don't-care.
  - sdo shifts to the next bit on each falling edge, for bits 1..31. After bit 31, sdo=0.
  - A 6-bit bit counter and a div counter track progress.
- Byte assembly is little-endian: the first received byte goes to dat_r[7:0] and the fourth to dat_r[31:24]. Bits within a byte arrive MSB first.
- DONE at cycle 1+128*CLK_DIV, in place of the final falling edge: sck=0, csn=1, t_ack=1 for exactly one cycle, t_dat_r valid. t_dat_r holds its value until the next read completes.
- GAP: csn stays high for CSN_GAP cycles, counted starting from the DONE cycle, then IDLE. A request pending during GAP is accepted in IDLE.
- Abort: t_cyc or t_stb low during SHIFT gives csn=1, sck=0, sdo=0 next cycle, then GAP; no ack, and t_dat_r is unchanged.
- t_ack and t_err are never asserted together and never asserted without t_cyc&t_stb on the acceptance cycle.

Decomposition:
- Package clusterv_spi_flash_pkg: state enum, CMD_READ=8'h03, N_CMD_ADDR_BITS=32, N_DATA_BITS=32.
- Sub-module spi_sck_gen (parameter CLK_DIV): enable in, sck out, plus single-cycle rise/fall strobes. It restarts with sck low whenever enable deasserts.

Test Plan:
- Read t_adr=0x100, BFM image bytes 11,22,33,44 at 0x100 -> sdo stream 0x03_000100, t_dat_r=0x44332211, t_ack exactly at cycle 257 (CLK_DIV=2), one cycle wide.
- Read t_adr=0xFF_ABCDEF -> address bits on sdo = 0xABCDEC, data from 0xABCDEC.
- Write to any address -> t_err high one cycle, t_ack never, csn stays 1 and sck stays 0 throughout.
- Two back-to-back reads (stb reasserted immediately) -> csn high for >= CSN_GAP cycles between them; both acks carry the correct data.
- t_cyc dropped at cycle 40 of a read -> csn=1 next cycle, no ack; the following read returns correct data.
- reset asserted at cycle 100 of a read -> next cycle csn=1, sck=0, ack=0, err=0, dat_r=0; the read after reset succeeds.

Source files
------------

// File: rtl/clusterv_spi_flash_pkg.sv
// Shared types and constants for the SPI flash read path.
//   state_t          : controller FSM states
//   CMD_READ         : SPI flash READ opcode
//   N_CMD_ADDR_BITS  : opcode + 24-bit address bits shifted out
//   N_DATA_BITS      : data bits shifted in per read
//   bswap32()        : reorders an MSB-first byte stream into a little-endian word
package clusterv_spi_flash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam int         N_CMD_ADDR_BITS = 32;
  localparam int         N_DATA_BITS     = 32;

  // The first byte received lands in [31:24] of the shift register and
  // belongs in [7:0] of the bus word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator.
//   clock, reset : system clock, synchronous active-high reset
//   en           : run the clock; when low, sck is forced low and the divider restarts
//   sck          : SPI clock, toggles every CLK_DIV clocks while en is high
//   rise, fall   : one-cycle strobes, high in the cycle before sck goes high/low,
//                  so the caller can update its registers on the same clock edge
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = en && (div_cnt == DW'(CLK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_spi_flash_rd.sv
// Wishbone target that turns 32-bit reads into SPI flash READ (0x03)
// transactions; writes are refused with t_err.
//   clock, reset       : system clock, synchronous active-high reset
//   t_adr/t_dat_w/t_sel: Wishbone address (only [23:2] used), write data and selects (unused)
//   t_cyc/t_stb/t_we   : Wishbone cycle, strobe, write enable
//   t_dat_r            : read data, held until the next read completes
//   t_ack / t_err      : one-cycle read completion / write rejection
//   flash_sck/csn/sdo  : SPI initiator outputs (mode 0)
//   flash_sdi          : SPI data from flash
module wb_spi_flash_rd
  import clusterv_spi_flash_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int CSN_GAP    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] t_adr,
  input  logic [31:0]           t_dat_w,
  output logic [31:0]           t_dat_r,
  input  logic                  t_cyc,
  input  logic                  t_stb,
  input  logic                  t_we,
  input  logic [3:0]            t_sel,
  output logic                  t_ack,
  output logic                  t_err,
  output logic                  flash_sck,
  output logic                  flash_csn,
  output logic                  flash_sdo,
  input  logic                  flash_sdi
);

  localparam int GW = $clog2(CSN_GAP + 2);

  state_t                     state, state_nxt;
  logic [N_CMD_ADDR_BITS-1:0] out_sh;
  logic [N_DATA_BITS-1:0]     in_sh;
  logic [5:0]                 bit_cnt;   // counts sck rising edges, wraps after 64
  logic [GW-1:0]              gap_cnt;   // csn-high cycles seen, DONE included
  logic                       err_q;
  logic [31:0]                dat_r_q;
  logic                       req, sck_en, sck_rise, sck_fall;

  logic unused;
  assign unused = ^{t_dat_w, t_sel, t_adr[ADDR_WIDTH-1:24], t_adr[1:0]};

  assign req = t_cyc && t_stb;

  // Dropping the request stops sck right away so the abort cycle sees sck low.
  // On the final falling edge sck returns low by its own toggle.
  assign sck_en = (state == ST_SHIFT) && req;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clock (clock),
    .reset (reset),
    .en    (sck_en),
    .sck   (flash_sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req && !t_we) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (!req)                           state_nxt = ST_GAP;
        // bit_cnt has wrapped to 0 only after rise 63, so this is the 64th fall
        else if (sck_fall && bit_cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_GAP;
      ST_GAP:   if (gap_cnt >= GW'(CSN_GAP)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      out_sh  <= '0;
      in_sh   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
    end else begin
      state <= state_nxt;
      // err_q in the term blocks a second err while the master is still dropping stb.
      err_q <= (state == ST_IDLE) && req && t_we && !err_q;
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_SHIFT) begin
            out_sh  <= {CMD_READ, t_adr[23:2], 2'b00};
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (state_nxt == ST_GAP) begin
            out_sh  <= '0;
            gap_cnt <= GW'(1);
          end else begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt[5]) in_sh <= {in_sh[N_DATA_BITS-2:0], flash_sdi};
            end
            // zero-fill so sdo falls to 0 after the last address bit
            if (sck_fall) out_sh <= {out_sh[N_CMD_ADDR_BITS-2:0], 1'b0};
            if (state_nxt == ST_DONE) begin
              dat_r_q <= bswap32(in_sh);
              gap_cnt <= GW'(1);
            end
          end
        end
        ST_DONE, ST_GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign flash_csn = (state != ST_SHIFT);
  assign flash_sdo = out_sh[N_CMD_ADDR_BITS-1];
  assign t_ack     = (state == ST_DONE);
  assign t_err     = err_q;
  assign t_dat_r   = dat_r_q;

endmodule
